// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory for the MEM stage: little-endian byte/half/word access with
// load extension, fault reporting, optional wait states and an optional reset-time clear sweep.
module dmem_bytelane #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DEPTH_WORDS    = 64,
    parameter int unsigned WAIT_STATES    = 0,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              ready,
    output logic              ack,
    output logic [31:0]       rdata,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StInit, StIdle, StWait} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic              up_q;
    logic              we_q, uns_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              ack_q, fault_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] fault_addr_q;
    logic [31:0]       mem [DEPTH_WORDS];

    logic              accept, perform, sweep_we;
    logic              op_we, op_uns, op_fault;
    logic [1:0]        op_size;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_wdata;
    logic [IDX_W-1:0]  widx;
    logic [31:0]       cur_word, shifted, mask, wsh, merged, load_val;

    // up_q keeps ready low while reset is held even when no sweep is needed
    assign ready  = up_q && (state_q == StIdle);
    assign accept = req && ready;

    // With wait states the access uses the operands captured at accept
    assign op_we    = (state_q == StWait) ? we_q    : we;
    assign op_size  = (state_q == StWait) ? size_q  : size;
    assign op_uns   = (state_q == StWait) ? uns_q   : uns;
    assign op_addr  = (state_q == StWait) ? addr_q  : addr;
    assign op_wdata = (state_q == StWait) ? wdata_q : wdata;

    assign widx     = op_addr[IDX_W+1:2];
    assign cur_word = mem[widx];
    assign op_fault = (op_size == 2'b11)
                   || (op_size == 2'b01 && op_addr[0])
                   || (op_size == 2'b10 && op_addr[1:0] != 2'b00)
                   || (op_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));

    always_comb begin
        mask     = 32'hFFFF_FFFF;
        wsh      = op_wdata;
        shifted  = cur_word;
        load_val = cur_word;
        case (op_size)
            2'b00: begin
                mask     = 32'h0000_00FF << {op_addr[1:0], 3'b000};
                wsh      = {24'h0, op_wdata[7:0]} << {op_addr[1:0], 3'b000};
                shifted  = cur_word >> {op_addr[1:0], 3'b000};
                load_val = {{24{~op_uns & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                mask     = 32'h0000_FFFF << {op_addr[1], 4'b0000};
                wsh      = {16'h0, op_wdata[15:0]} << {op_addr[1], 4'b0000};
                shifted  = cur_word >> {op_addr[1], 4'b0000};
                load_val = {{16{~op_uns & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

    assign merged = (cur_word & ~mask) | (wsh & mask);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sweep_d  = sweep_q;
        perform  = 1'b0;
        sweep_we = 1'b0;
        unique case (state_q)
            StInit: begin
                sweep_we = 1'b1;
                sweep_d  = sweep_q + 1'b1;
                if (sweep_q == IDX_W'(DEPTH_WORDS - 1)) state_d = StIdle;
            end
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        perform = 1'b1;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(WAIT_STATES);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd1) begin
                    perform = 1'b1;
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= CLEAR_ON_RESET ? StInit : StIdle;
            cnt_q        <= 4'd0;
            sweep_q      <= '0;
            up_q         <= 1'b0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            ack_q        <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= 32'h0;
            fault_addr_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sweep_q <= sweep_d;
            up_q    <= 1'b1;
            ack_q   <= perform;
            fault_q <= perform && op_fault;
            if (accept) begin
                we_q    <= we;
                uns_q   <= uns;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (perform) begin
                if (op_fault) begin
                    rdata_q      <= 32'h0;
                    fault_addr_q <= op_addr;
                end else if (!op_we) begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[sweep_q] <= 32'h0;
        end else if (perform && op_we && !op_fault) begin
            mem[widx] <= merged;
        end
    end

    assign ack        = ack_q;
    assign fault      = fault_q;
    assign rdata      = rdata_q;
    assign fault_addr = fault_addr_q;

endmodule
